// File: rtl/bank_conflict_arbiter_if.sv
// Requester and memory-issue bundle for bank_conflict_arbiter.
// master: requester/memory side; slave: the arbiter.
// The conflict_cnt signal exists only when ARB_STATS_EN is defined.
interface bank_conflict_arbiter_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  req_a;
  logic                  req_b;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic                  we_a;
  logic                  we_b;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic                  ready_a;
  logic                  ready_b;
  logic                  mem_en_a;
  logic                  mem_en_b;
  logic [ADDR_WIDTH-1:0] mem_addr_a;
  logic [ADDR_WIDTH-1:0] mem_addr_b;
  logic                  mem_we_a;
  logic                  mem_we_b;
  logic [DATA_WIDTH-1:0] mem_wdata_a;
  logic [DATA_WIDTH-1:0] mem_wdata_b;
  logic                  conflict;
`ifdef ARB_STATS_EN
  logic [CNT_WIDTH-1:0]  conflict_cnt;

  modport master (
    output req_a, req_b, addr_a, addr_b, we_a, we_b, wdata_a, wdata_b,
    input  ready_a, ready_b, mem_en_a, mem_en_b, mem_addr_a, mem_addr_b,
           mem_we_a, mem_we_b, mem_wdata_a, mem_wdata_b, conflict, conflict_cnt
  );
  modport slave (
    input  req_a, req_b, addr_a, addr_b, we_a, we_b, wdata_a, wdata_b,
    output ready_a, ready_b, mem_en_a, mem_en_b, mem_addr_a, mem_addr_b,
           mem_we_a, mem_we_b, mem_wdata_a, mem_wdata_b, conflict, conflict_cnt
  );
`else
  modport master (
    output req_a, req_b, addr_a, addr_b, we_a, we_b, wdata_a, wdata_b,
    input  ready_a, ready_b, mem_en_a, mem_en_b, mem_addr_a, mem_addr_b,
           mem_we_a, mem_we_b, mem_wdata_a, mem_wdata_b, conflict
  );
  modport slave (
    input  req_a, req_b, addr_a, addr_b, we_a, we_b, wdata_a, wdata_b,
    output ready_a, ready_b, mem_en_a, mem_en_b, mem_addr_a, mem_addr_b,
           mem_we_a, mem_we_b, mem_wdata_a, mem_wdata_b, conflict
  );
`endif
endinterface

// File: rtl/bank_conflict_arbiter.sv
// Two-requester same-bank conflict arbiter with round-robin priority.
// Accepted accesses are registered onto two memory issue ports.
// Optional macro ARB_STATS_EN adds the saturating conflict_cnt counter.
// Data/counter widths come from the connected interface instance.
module bank_conflict_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int BANK_LOG2  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bank_conflict_arbiter_if.slave  bus
);

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} state_t;

  state_t               state;
  state_t               state_next;
  logic [BANK_LOG2-1:0] bank_a;
  logic [BANK_LOG2-1:0] bank_b;
  logic                 collision;
  logic                 accept_a;
  logic                 accept_b;

  // Bank decode and same-bank collision detect
  always_comb begin
    bank_a    = bus.addr_a[ADDR_WIDTH-1 -: BANK_LOG2];
    bank_b    = bus.addr_b[ADDR_WIDTH-1 -: BANK_LOG2];
    collision = bus.req_a && bus.req_b && (bank_a == bank_b);
  end

  // Priority state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PRIO_A;
    else        state <= state_next;
  end

  // Next priority: hand priority to the loser of a collision
  always_comb begin
    state_next = state;
    if (collision) begin
      case (state)
        PRIO_A:  state_next = PRIO_B;
        PRIO_B:  state_next = PRIO_A;
        default: state_next = PRIO_A;
      endcase
    end
  end

  // Grants: everyone is ready unless a collision, then only the prio holder
  always_comb begin
    bus.ready_a = !collision || (state == PRIO_A);
    bus.ready_b = !collision || (state == PRIO_B);
    accept_a    = bus.req_a && bus.ready_a;
    accept_b    = bus.req_b && bus.ready_b;
  end

  // Issue registers; address/we/data hold their last accepted value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_en_a    <= 1'b0;
      bus.mem_en_b    <= 1'b0;
      bus.mem_addr_a  <= '0;
      bus.mem_addr_b  <= '0;
      bus.mem_we_a    <= 1'b0;
      bus.mem_we_b    <= 1'b0;
      bus.mem_wdata_a <= '0;
      bus.mem_wdata_b <= '0;
      bus.conflict    <= 1'b0;
    end else begin
      bus.mem_en_a <= accept_a;
      bus.mem_en_b <= accept_b;
      bus.conflict <= collision;
      if (accept_a) begin
        bus.mem_addr_a  <= bus.addr_a;
        bus.mem_we_a    <= bus.we_a;
        bus.mem_wdata_a <= bus.wdata_a;
      end
      if (accept_b) begin
        bus.mem_addr_b  <= bus.addr_b;
        bus.mem_we_b    <= bus.we_b;
        bus.mem_wdata_b <= bus.wdata_b;
      end
    end
  end

`ifdef ARB_STATS_EN
  // Saturating collision counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.conflict_cnt <= '0;
    else if (collision && (bus.conflict_cnt != '1))
      bus.conflict_cnt <= bus.conflict_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_bank_conflict_arbiter.sv
// Scoreboard bench for bank_conflict_arbiter. Expected issue-port values
// are computed from a bench-side priority model when stimulus is driven
// and compared one cycle later. Counter checks apply with ARB_STATS_EN.
module tb_bank_conflict_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct {
    logic          en_a;
    logic [AW-1:0] addr_a;
    logic          we_a;
    logic [DW-1:0] wd_a;
    logic          en_b;
    logic [AW-1:0] addr_b;
    logic          we_b;
    logic [DW-1:0] wd_b;
    logic          conflict;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;

  bank_conflict_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  bank_conflict_arbiter #(.ADDR_WIDTH(AW), .BANK_LOG2(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_pass;
  exp_t        sb[$];

  // Bench model state
  logic          m_prio;  // 0 = A, 1 = B
  logic [AW-1:0] m_addr_a, m_addr_b;
  logic          m_we_a, m_we_b;
  logic [DW-1:0] m_wd_a, m_wd_b;
  logic [CW-1:0] m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_prio = 1'b0;
    m_addr_a = '0; m_addr_b = '0;
    m_we_a = 1'b0; m_we_b = 1'b0;
    m_wd_a = '0; m_wd_b = '0;
    m_cnt = '0;
    sb.delete();
  endtask

  // Drive one cycle of stimulus, check ready, push and then check the issue.
  task automatic drive(input logic ra, input logic [AW-1:0] aa, input logic wa, input logic [DW-1:0] da,
                       input logic rb, input logic [AW-1:0] ab, input logic wb, input logic [DW-1:0] db);
    exp_t e;
    logic col, rdy_a, rdy_b;
    bus.req_a = ra; bus.addr_a = aa; bus.we_a = wa; bus.wdata_a = da;
    bus.req_b = rb; bus.addr_b = ab; bus.we_b = wb; bus.wdata_b = db;
    col   = ra && rb && (aa[AW-1:AW-2] == ab[AW-1:AW-2]);
    rdy_a = !col || (m_prio == 1'b0);
    rdy_b = !col || (m_prio == 1'b1);
    #1;
    check_eq("ready_a", bus.ready_a, rdy_a);
    check_eq("ready_b", bus.ready_b, rdy_b);
    e.en_a = ra && rdy_a;
    e.en_b = rb && rdy_b;
    if (e.en_a) begin m_addr_a = aa; m_we_a = wa; m_wd_a = da; end
    if (e.en_b) begin m_addr_b = ab; m_we_b = wb; m_wd_b = db; end
    if (col) begin
      m_prio = rdy_a ? 1'b1 : 1'b0;  // priority goes to the loser
      if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    end
    e.addr_a = m_addr_a; e.we_a = m_we_a; e.wd_a = m_wd_a;
    e.addr_b = m_addr_b; e.we_b = m_we_b; e.wd_b = m_wd_b;
    e.conflict = col;
    e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("mem_en_a", bus.mem_en_a, e.en_a);
    check_eq("mem_en_b", bus.mem_en_b, e.en_b);
    check_eq("mem_addr_a", bus.mem_addr_a, e.addr_a);
    check_eq("mem_addr_b", bus.mem_addr_b, e.addr_b);
    check_eq("mem_we_a", bus.mem_we_a, e.we_a);
    check_eq("mem_we_b", bus.mem_we_b, e.we_b);
    check_eq("mem_wdata_a", bus.mem_wdata_a, e.wd_a);
    check_eq("mem_wdata_b", bus.mem_wdata_b, e.wd_b);
    check_eq("conflict", bus.conflict, e.conflict);
`ifdef ARB_STATS_EN
    check_eq("conflict_cnt", bus.conflict_cnt, e.cnt);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();

    // Reset held with both requesting the same bank
    rst_n = 1'b0;
    bus.req_a = 1'b1; bus.addr_a = 13'h1000; bus.we_a = 1'b1; bus.wdata_a = 32'h1;
    bus.req_b = 1'b1; bus.addr_b = 13'h1010; bus.we_b = 1'b1; bus.wdata_b = 32'h2;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mem_en_a", bus.mem_en_a, 1'b0);
    check_eq("rst_mem_en_b", bus.mem_en_b, 1'b0);
    check_eq("rst_conflict", bus.conflict, 1'b0);
    check_eq("rst_mem_addr_a", bus.mem_addr_a, 13'h0);
`ifdef ARB_STATS_EN
    check_eq("rst_cnt", bus.conflict_cnt, 4'h0);
`endif
    rst_n = 1'b1;

    // First collision after reset grants A
    drive(1'b1, 13'h1000, 1'b1, 32'hA0, 1'b1, 13'h1010, 1'b1, 32'hB0);
    // B retries and wins
    drive(1'b1, 13'h1000, 1'b1, 32'hA0, 1'b1, 13'h1010, 1'b1, 32'hB0);

    // No collision: bank 0 vs bank 1 reads
    drive(1'b1, 13'h0004, 1'b0, 32'h0, 1'b1, 13'h0804, 1'b0, 32'h0);
    drive(1'b1, 13'h0008, 1'b1, 32'h11, 1'b1, 13'h0808, 1'b1, 32'h22);

    // Persistent collision on bank 2 for 4 cycles: A, B, A, B
    for (int i = 0; i < 4; i++)
      drive(1'b1, 13'h1000, 1'b1, 32'hC0 + i, 1'b1, 13'h1010, 1'b1, 32'hD0 + i);

    // Loser retry: A wins, then B alone, then collide again
    drive(1'b1, 13'h1000, 1'b0, 32'h0, 1'b1, 13'h1010, 1'b0, 32'h0);
    drive(1'b0, 13'h0000, 1'b0, 32'h0, 1'b1, 13'h1010, 1'b0, 32'h0);
    drive(1'b1, 13'h1004, 1'b1, 32'h55, 1'b1, 13'h1014, 1'b1, 32'h66);

    // Idle cycle: both ready, nothing issued
    drive(1'b0, 13'h1000, 1'b0, 32'h0, 1'b0, 13'h1000, 1'b0, 32'h0);

    // Mid-operation reset: move prio to B, accept a lone A, then pulse reset
    drive(1'b1, 13'h1000, 1'b0, 32'h0, 1'b1, 13'h1010, 1'b0, 32'h0);
    if (m_prio == 1'b0)
      drive(1'b1, 13'h1000, 1'b0, 32'h0, 1'b1, 13'h1010, 1'b0, 32'h0);
    drive(1'b1, 13'h0123, 1'b1, 32'hDEAD, 1'b0, 13'h0000, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_mem_en_a", bus.mem_en_a, 1'b0);
    check_eq("async_mem_addr_a", bus.mem_addr_a, 13'h0);
    check_eq("async_mem_wdata_a", bus.mem_wdata_a, 32'h0);
    rst_n = 1'b1;
    model_reset();
    drive(1'b1, 13'h1800, 1'b0, 32'h0, 1'b1, 13'h1810, 1'b0, 32'h0);

    // Random traffic with narrow banks to mix hits and misses
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] ra, rb2;
      ra  = AW'($urandom);
      rb2 = AW'($urandom);
      drive(1'($urandom), ra, 1'($urandom), $urandom,
            1'($urandom), rb2, 1'($urandom), $urandom);
    end

    // Counter saturation: 20 consecutive collisions
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++)
      drive(1'b1, 13'h0400, 1'b1, 32'h100 + i, 1'b1, 13'h0410, 1'b1, 32'h200 + i);
`ifdef ARB_STATS_EN
    check_eq("cnt_saturated", bus.conflict_cnt, 4'hF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
